// File: rtl/sa_cache_pkg.sv
// Shared types and width helpers for the set-associative cache controller.
// Optional statistics counters are enabled with the CACHE_STATS_EN macro (see sa_cache_ctrl).
package sa_cache_pkg;

  // Default geometry; the top-level parameters start from these values.
  localparam int ADDR_W_DEF     = 12;
  localparam int WORD_W_DEF     = 32;
  localparam int SETS_DEF       = 8;
  localparam int WAYS_DEF       = 4;
  localparam int LINE_WORDS_DEF = 4;

  // Address field widths derived from the geometry: addr = {tag, index, offset}.
  function automatic int ofs_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int sets, input int line_words);
    return addr_w - idx_w(sets) - ofs_w(line_words);
  endfunction

  localparam int TAG_W_DEF = tag_w(ADDR_W_DEF, SETS_DEF, LINE_WORDS_DEF);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB,
    REFILL,
    RESP
  } state_e;

  // Per-way state bits kept beside each stored tag.
  typedef struct packed {
    logic valid;
    logic dirty;
  } tag_entry_t;

  // One full cache line at the default geometry, word 0 in the low bits.
  typedef logic [LINE_WORDS_DEF*WORD_W_DEF-1:0] line_t;

endpackage

// File: rtl/sa_cache_victim_sel.sv
// Victim way choice: lowest-index invalid way, otherwise the set's round-robin pointer.
module sa_cache_victim_sel #(
  parameter int WAYS  = 4,
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0]  valid_i,
  input  logic [WAY_W-1:0] rr_ptr_i,
  output logic [WAY_W-1:0] victim_o,
  output logic             victim_valid_o
);

  // Scan from the top way down so the lowest invalid way wins.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
    victim_o       = rr_ptr_i;
    victim_valid_o = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) begin
        victim_o       = WAY_W'(w);
        victim_valid_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sa_cache_ctrl.sv
// N-way set-associative, write-back, write-allocate cache controller.
// Define CACHE_STATS_EN to add saturating hit/miss/write-back counters and their ports.
module sa_cache_ctrl
  import sa_cache_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int WORD_W     = WORD_W_DEF,
  parameter int SETS       = SETS_DEF,
  parameter int WAYS       = WAYS_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cpu_req_valid,
  output logic                         cpu_req_ready,
  input  logic                         cpu_req_we,
  input  logic [ADDR_W-1:0]            cpu_req_addr,
  input  logic [WORD_W-1:0]            cpu_req_wdata,
  output logic                         cpu_resp_valid,
  output logic [WORD_W-1:0]            cpu_resp_rdata,
  output logic                         cpu_resp_hit,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDR_W-ofs_w(LINE_WORDS)-1:0] mem_addr,
  output logic [LINE_WORDS*WORD_W-1:0] mem_wdata,
  input  logic                         mem_ready,
  input  logic [LINE_WORDS*WORD_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                  stat_hits,
  output logic [31:0]                  stat_misses,
  output logic [31:0]                  stat_wbacks
`endif
);

  localparam int OFS_W  = ofs_w(LINE_WORDS);
  localparam int IDX_W  = idx_w(SETS);
  localparam int TAG_W  = tag_w(ADDR_W, SETS, LINE_WORDS);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int LINE_W = LINE_WORDS * WORD_W;

  state_e              state_q, state_d;
  logic                req_we_q, req_we_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [WORD_W-1:0]   req_wdata_q, req_wdata_d;
  logic [WAY_W-1:0]    way_q, way_d;
  logic                hit_q, hit_d;
  logic [WORD_W-1:0]   rdata_q, rdata_d;
  logic                resp_valid_q, resp_valid_d;
  tag_entry_t          status_q [SETS][WAYS];
  tag_entry_t          status_d [SETS][WAYS];
  logic [WAY_W-1:0]    rr_q [SETS];
  logic [WAY_W-1:0]    rr_d [SETS];

  logic [TAG_W-1:0]    tag_mem  [SETS][WAYS];
  logic [LINE_W-1:0]   data_mem [SETS][WAYS];
  logic                tag_we, line_we;
  logic [LINE_W-1:0]   line_wdata;

  logic [IDX_W-1:0]    req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic [OFS_W-1:0]    req_ofs;
  logic [LINE_W-1:0]   line_cur;
  logic [WAYS-1:0]     set_valid;
  logic                hit_any;
  logic [WAY_W-1:0]    hit_way;
  logic [WAY_W-1:0]    victim_way;
  logic                victim_valid;
  logic                need_wb;

  assign req_ofs  = req_addr_q[OFS_W-1:0];
  assign req_idx  = req_addr_q[OFS_W +: IDX_W];
  assign req_tag  = req_addr_q[ADDR_W-1 -: TAG_W];
  assign line_cur = data_mem[req_idx][way_q];

  // Tag compare across the addressed set; at most one way can match.
  always_comb begin
    hit_any   = 1'b0;
    hit_way   = '0;
    set_valid = '0;
    for (int w = 0; w < WAYS; w++) begin
      set_valid[w] = status_q[req_idx][w].valid;
      if (status_q[req_idx][w].valid && (tag_mem[req_idx][w] == req_tag)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  sa_cache_victim_sel #(
    .WAYS (WAYS)
  ) u_victim_sel (
    .valid_i        (set_valid),
    .rr_ptr_i       (rr_q[req_idx]),
    .victim_o       (victim_way),
    .victim_valid_o (victim_valid)
  );

  assign need_wb = victim_valid && status_q[req_idx][victim_way].dirty;

  // Next-state, request capture and array-update decisions.
  always_comb begin
    // NOTE: combinational logic uses blocking '=' so later statements see earlier updates within the block.
    state_d      = state_q;
    req_we_d     = req_we_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    way_d        = way_q;
    hit_d        = hit_q;
    rdata_d      = rdata_q;
    resp_valid_d = 1'b0;
    status_d     = status_q;
    rr_d         = rr_q;
    tag_we       = 1'b0;
    line_we      = 1'b0;
    line_wdata   = line_cur;
    unique case (state_q)
      IDLE: begin
        if (cpu_req_valid) begin
          req_we_d    = cpu_req_we;
          req_addr_d  = cpu_req_addr;
          req_wdata_d = cpu_req_wdata;
          state_d     = LOOKUP;
        end
      end
      LOOKUP: begin
        hit_d = hit_any;
        if (hit_any) begin
          way_d   = hit_way;
          state_d = RESP;
        end else begin
          way_d = victim_way;
          if (victim_valid) rr_d[req_idx] = rr_q[req_idx] + WAY_W'(1);
          state_d = need_wb ? WB : REFILL;
        end
      end
      WB: begin
        if (mem_ready) state_d = REFILL;
      end
      REFILL: begin
        if (mem_ready) begin
          tag_we     = 1'b1;
          line_we    = 1'b1;
          line_wdata = mem_rdata;
          status_d[req_idx][way_q] = '{valid: 1'b1, dirty: 1'b0};
          state_d    = RESP;
        end
      end
      RESP: begin
        if (req_we_q) begin
          line_we = 1'b1;
          line_wdata[req_ofs*WORD_W +: WORD_W] = req_wdata_q;
          status_d[req_idx][way_q].dirty = 1'b1;
        end else begin
          rdata_d = line_cur[req_ofs*WORD_W +: WORD_W];
        end
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q      <= IDLE;
      req_we_q     <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      way_q        <= '0;
      hit_q        <= 1'b0;
      rdata_q      <= '0;
      resp_valid_q <= 1'b0;
      status_q     <= '{default: '0};
      rr_q         <= '{default: '0};
    end else begin
      state_q      <= state_d;
      req_we_q     <= req_we_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      way_q        <= way_d;
      hit_q        <= hit_d;
      rdata_q      <= rdata_d;
      resp_valid_q <= resp_valid_d;
      status_q     <= status_d;
      rr_q         <= rr_d;
    end
  end

  // Tag and data storage writes.
  always_ff @(posedge clk) begin
    // NOTE: tag/data arrays carry no reset; the cleared valid bits make their contents irrelevant.
    if (tag_we)  tag_mem[req_idx][way_q]  <= req_tag;
    if (line_we) data_mem[req_idx][way_q] <= line_wdata;
  end

  assign cpu_req_ready  = (state_q == IDLE);
  assign cpu_resp_valid = resp_valid_q;
  assign cpu_resp_rdata = rdata_q;
  assign cpu_resp_hit   = hit_q;
  assign mem_req        = (state_q == WB) || (state_q == REFILL);
  assign mem_we         = (state_q == WB);
  assign mem_addr       = (state_q == WB) ? {tag_mem[req_idx][way_q], req_idx}
                                          : {req_tag, req_idx};
  assign mem_wdata      = line_cur;

`ifdef CACHE_STATS_EN
  logic [31:0] hits_q, hits_d, misses_q, misses_d, wbacks_q, wbacks_d;

  // Saturating event counters updated on LOOKUP outcome.
  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    wbacks_d = wbacks_q;
    if (state_q == LOOKUP) begin
      if (hit_any) begin
        if (hits_q != '1) hits_d = hits_q + 32'd1;
      end else begin
        if (misses_q != '1) misses_d = misses_q + 32'd1;
        if (need_wb && (wbacks_q != '1)) wbacks_d = wbacks_q + 32'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hits_q   <= '0;
      misses_q <= '0;
      wbacks_q <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
      wbacks_q <= wbacks_d;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
  assign stat_wbacks = wbacks_q;
`endif

endmodule

// File: tb/tb_sa_cache_ctrl.sv
// Self-checking bench for sa_cache_ctrl: directed scenarios plus randomized traffic
// compared against a transaction-level cache model and a latency-randomized memory.
module tb_sa_cache_ctrl;
  import sa_cache_pkg::*;

  localparam int ADDR_W = 12;
  localparam int WORD_W = 32;
  localparam int SETS   = 8;
  localparam int WAYS   = 4;
  localparam int LW     = 4;
  localparam int LINE_W = LW * WORD_W;
  localparam int LA_W   = 10;

  logic              clk;
  logic              rst_n;
  logic              cpu_req_valid;
  logic              cpu_req_ready;
  logic              cpu_req_we;
  logic [ADDR_W-1:0] cpu_req_addr;
  logic [WORD_W-1:0] cpu_req_wdata;
  logic              cpu_resp_valid;
  logic [WORD_W-1:0] cpu_resp_rdata;
  logic              cpu_resp_hit;
  logic              mem_req;
  logic              mem_we;
  logic [LA_W-1:0]   mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [LINE_W-1:0] mem_rdata;
`ifdef CACHE_STATS_EN
  logic [31:0]       stat_hits, stat_misses, stat_wbacks;
`endif

  sa_cache_ctrl #(
    .ADDR_W(ADDR_W), .WORD_W(WORD_W), .SETS(SETS), .WAYS(WAYS), .LINE_WORDS(LW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_req_we     (cpu_req_we),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_req_wdata  (cpu_req_wdata),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_resp_rdata (cpu_resp_rdata),
    .cpu_resp_hit   (cpu_resp_hit),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_ready      (mem_ready),
    .mem_rdata      (mem_rdata)
`ifdef CACHE_STATS_EN
    ,
    .stat_hits      (stat_hits),
    .stat_misses    (stat_misses),
    .stat_wbacks    (stat_wbacks)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- memory model driven by the DUT's memory port ----------------
  logic [31:0]     dstore [int];
  logic [LA_W-1:0] wb_addr_q [$];
  line_t           wb_data_q [$];
  logic [LA_W-1:0] rf_addr_q [$];
  logic            hold_mem = 1'b0;

  function automatic logic [31:0] dut_word(input int line, input int ofs);
    if (dstore.exists(line * LW + ofs)) return dstore[line * LW + ofs];
    return 32'(line * 16 + ofs);
  endfunction

  initial begin
    logic            pend;
    logic            cap_we;
    logic [LA_W-1:0] cap_addr;
    line_t           cap_wdata;
    int              cnt;
    pend      = 1'b0;
    cap_we    = 1'b0;
    cap_addr  = '0;
    cap_wdata = '0;
    cnt       = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_ready) begin
        mem_ready = 1'b0;
        pend      = 1'b0;
      end
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          check("mem_req_held", mem_req, 1'b1);
          check("mem_we_stable", mem_we, cap_we);
          check("mem_addr_stable", mem_addr, cap_addr);
          if (cap_we) check("mem_wdata_stable", mem_wdata, cap_wdata);
        end
        if (!mem_req) begin
          pend = 1'b0;
        end else begin
          if (!pend) begin
            pend      = 1'b1;
            cap_we    = mem_we;
            cap_addr  = mem_addr;
            cap_wdata = mem_wdata;
            cnt       = $urandom_range(0, 3);
          end
          if (!hold_mem) begin
            if (cnt == 0) begin
              mem_ready = 1'b1;
              if (cap_we) begin
                wb_addr_q.push_back(cap_addr);
                wb_data_q.push_back(cap_wdata);
                for (int o = 0; o < LW; o++) dstore[int'(cap_addr) * LW + o] = cap_wdata[o*WORD_W +: WORD_W];
              end else begin
                rf_addr_q.push_back(cap_addr);
                for (int o = 0; o < LW; o++) mem_rdata[o*WORD_W +: WORD_W] = dut_word(int'(cap_addr), o);
              end
            end else begin
              cnt--;
            end
          end
        end
      end
    end
  end

  // ---------------- transaction-level reference cache ----------------
  logic        m_valid [SETS][WAYS];
  logic        m_dirty [SETS][WAYS];
  int          m_tag   [SETS][WAYS];
  logic [31:0] m_line  [SETS][WAYS][LW];
  int          m_rr    [SETS];
  logic [31:0] m_last_rd;
  int          m_hits, m_misses, m_wbs;
  logic [31:0] m_store [int];

  function automatic logic [31:0] mdl_word(input int line, input int ofs);
    if (m_store.exists(line * LW + ofs)) return m_store[line * LW + ofs];
    return 32'(line * 16 + ofs);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
    end
    m_last_rd = '0;
    m_hits    = 0;
    m_misses  = 0;
    m_wbs     = 0;
  endtask

  task automatic model_access(input logic we, input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                              output logic hit, output logic [31:0] rd, output logic wb,
                              output logic [LA_W-1:0] wb_line, output line_t wb_data,
                              output logic [LA_W-1:0] rf_line);
    int idx, tag, ofs, way;
    idx     = int'(addr) / 4 % SETS;
    tag     = int'(addr) / 32;
    ofs     = int'(addr) % 4;
    way     = -1;
    wb      = 1'b0;
    wb_line = '0;
    wb_data = '0;
    rf_line = '0;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[idx][w] && m_tag[idx][w] == tag) way = w;
    hit = (way >= 0);
    if (hit) begin
      m_hits++;
    end else begin
      m_misses++;
      for (int w = WAYS - 1; w >= 0; w--)
        if (!m_valid[idx][w]) way = w;
      if (way < 0) begin
        way = m_rr[idx];
        m_rr[idx] = (m_rr[idx] + 1) % WAYS;
        if (m_dirty[idx][way]) begin
          wb = 1'b1;
          m_wbs++;
          wb_line = LA_W'(m_tag[idx][way] * SETS + idx);
          for (int o = 0; o < LW; o++) begin
            wb_data[o*WORD_W +: WORD_W] = m_line[idx][way][o];
            m_store[int'(wb_line) * LW + o] = m_line[idx][way][o];
          end
        end
      end
      rf_line = LA_W'(int'(addr) / 4);
      for (int o = 0; o < LW; o++) m_line[idx][way][o] = mdl_word(int'(rf_line), o);
      m_valid[idx][way] = 1'b1;
      m_dirty[idx][way] = 1'b0;
      m_tag[idx][way]   = tag;
    end
    if (we) begin
      m_line[idx][way][ofs] = wdata;
      m_dirty[idx][way]     = 1'b1;
      rd = m_last_rd;
    end else begin
      rd = m_line[idx][way][ofs];
      m_last_rd = rd;
    end
  endtask

  // ---------------- CPU-side transaction with per-response comparison ----------------
  int last_lat;

  task automatic access(input logic we, input logic [ADDR_W-1:0] addr, input logic [31:0] wdata);
    logic            e_hit, e_wb;
    logic [31:0]     e_rd;
    logic [LA_W-1:0] e_wbl, e_rfl;
    line_t           e_wbd;
    int              lat, guard;
    model_access(we, addr, wdata, e_hit, e_rd, e_wb, e_wbl, e_wbd, e_rfl);
    wb_addr_q.delete();
    wb_data_q.delete();
    rf_addr_q.delete();
    guard = 0;
    while (!cpu_req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready", cpu_req_ready, 1'b1);
    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    cpu_req_addr  = addr;
    cpu_req_wdata = wdata;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    lat = 1;
    while (!cpu_resp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    last_lat = lat;
    check("resp_valid", cpu_resp_valid, 1'b1);
    check("resp_hit", cpu_resp_hit, e_hit);
    check("resp_rdata", cpu_resp_rdata, e_rd);
    if (e_hit) check("hit_latency", lat, 3);
    check("wb_count", wb_addr_q.size(), e_wb);
    if (e_wb && wb_addr_q.size() > 0) begin
      check("wb_addr", wb_addr_q[0], e_wbl);
      check("wb_data", wb_data_q[0], e_wbd);
    end
    check("refill_count", rf_addr_q.size(), !e_hit);
    if (!e_hit && rf_addr_q.size() > 0) check("refill_addr", rf_addr_q[0], e_rfl);
    @(negedge clk);
    check("resp_pulse", cpu_resp_valid, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},      cpu_req_ready,  1'b1);
    check({tag, "_resp_valid"}, cpu_resp_valid, 1'b0);
    check({tag, "_resp_hit"},   cpu_resp_hit,   1'b0);
    check({tag, "_resp_rdata"}, cpu_resp_rdata, 32'h0);
    check({tag, "_mem_req"},    mem_req,        1'b0);
    check({tag, "_mem_we"},     mem_we,         1'b0);
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    int guard;
    rst_n         = 1'b0;
    cpu_req_valid = 1'b0;
    cpu_req_we    = 1'b0;
    cpu_req_addr  = '0;
    cpu_req_wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // 1: write miss allocates line 0x08
    access(1'b1, 12'h022, 32'd3);
    check("s1_hit", cpu_resp_hit, 1'b0);
    check("s1_refill_line", rf_addr_q[0], 10'h008);
    check("s1_no_wb", wb_addr_q.size(), 0);

    // 2: read hit returns written word with fixed latency
    access(1'b0, 12'h022, 32'd0);
    check("s2_hit", cpu_resp_hit, 1'b1);
    check("s2_rdata", cpu_resp_rdata, 32'd3);
    check("s2_latency", last_lat, 3);

    // 3: fill the rest of set 0, then evict dirty way 0
    access(1'b0, 12'h042, 32'd0);
    access(1'b0, 12'h0A2, 32'd0);
    access(1'b0, 12'h122, 32'd0);
    access(1'b0, 12'h1A2, 32'd0);
    check("s3_wb_line", wb_addr_q[0], 10'h008);
    check("s3_wb_data", wb_data_q[0], 128'h00000083_00000003_00000081_00000080);
    check("s3_rdata", cpu_resp_rdata, 32'h682);

    // 4: clean eviction of way 1, no write-back
    access(1'b0, 12'h322, 32'd0);
    check("s4_no_wb", wb_addr_q.size(), 0);
    check("s4_rdata", cpu_resp_rdata, 32'hC82);
`ifdef CACHE_STATS_EN
    check("stat_hits", stat_hits, 32'd1);
    check("stat_misses", stat_misses, 32'd6);
    check("stat_wbacks", stat_wbacks, 32'd1);
`endif

    // 5: reset while a refill is outstanding
    hold_mem = 1'b1;
    cpu_req_valid = 1'b1;
    cpu_req_we    = 1'b0;
    cpu_req_addr  = 12'h022;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    guard = 0;
    while (!(mem_req && !mem_we) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("s5_refill_pending", mem_req, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("s5");
    @(negedge clk);
    rst_n    = 1'b1;
    hold_mem = 1'b0;
    model_reset();
    access(1'b0, 12'h022, 32'd0);
    check("s5_miss_after_reset", cpu_resp_hit, 1'b0);
    access(1'b0, 12'h322, 32'd0);
    check("s5_resident_lost", cpu_resp_hit, 1'b0);

    // 6: randomized traffic concentrated on two sets to force evictions
    for (int i = 0; i < 400; i++) begin
      logic [ADDR_W-1:0] a;
      a = {7'($urandom_range(0, 5)), 3'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
      access(1'($urandom_range(0, 1)), a, $urandom);
    end
`ifdef CACHE_STATS_EN
    check("stat_hits_final", stat_hits, 32'(m_hits));
    check("stat_misses_final", stat_misses, 32'(m_misses));
    check("stat_wbacks_final", stat_wbacks, 32'(m_wbs));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
    $fatal(1);
  end

endmodule
